// File: rtl/hilo_div_writer.sv
// Iterative radix-2 restoring divider that produces the packed {HI=remainder, LO=quotient} write.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes straight from IDLE without iterating.
module hilo_div_writer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               busy,
  output logic               hilo_we,
  output logic [2*WIDTH-1:0] hilo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     hilo_q, hilo_d;

  // quo_q starts as the dividend magnitude; its msb feeds each step and quotient bits shift in at the lsb
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       dvsr_q, dvsr_d;
  logic [WIDTH-1:0]       araw_q, araw_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic                   bzero_q, bzero_d;

  logic [WIDTH:0]         rem_shift;
  logic [WIDTH:0]         trial;
  logic                   no_borrow;
  logic [WIDTH-1:0]       rem_next;
  logic [WIDTH-1:0]       quo_next;
  logic                   last_step;
  logic                   accept;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                     is_signed);
    return (is_signed && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  // Two's-complement negate with wrap; the most negative value maps to itself.
  function automatic logic [WIDTH-1:0] negate_if(input logic signed [WIDTH-1:0] v,
                                                 input logic                     en);
    return en ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  // Restoring step
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    no_borrow = ~trial[WIDTH];
    rem_next  = no_borrow ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], no_borrow};
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
    accept    = start && !cancel;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hilo_q  <= hilo_d;
    end
  end

  // Operand and iteration registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    quo_q     <= quo_d;
    rem_q     <= rem_d;
    dvsr_q    <= dvsr_d;
    araw_q    <= araw_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    bzero_q   <= bzero_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = (b == '0) ? S_DONE : S_DIV;
`else
          state_d = S_DIV;
`endif
        end
      end
      S_DIV: begin
        if (cancel)         state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates
  always_comb begin
    cnt_d     = cnt_q;
    hilo_d    = hilo_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    araw_d    = araw_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          quo_d     = magnitude(a, signed_div);
          dvsr_d    = magnitude(b, signed_div);
          rem_d     = '0;
          araw_d    = a;
          neg_quo_d = signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_div && a[WIDTH-1];
          bzero_d   = (b == '0);
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) hilo_d = {a, {WIDTH{1'b1}}};
`endif
        end
      end
      S_DIV: begin
        if (!cancel) begin
          cnt_d = cnt_q + 1'b1;
          quo_d = quo_next;
          rem_d = rem_next;
          if (last_step) begin
            // A zero divisor reports the raw dividend as remainder, never sign-corrected
            if (bzero_q) hilo_d = {araw_q, {WIDTH{1'b1}}};
            else         hilo_d = {negate_if(rem_next, neg_rem_q), negate_if(quo_next, neg_quo_q)};
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_q == S_DIV);
    hilo_we = (state_q == S_DONE);
    hilo_o  = hilo_q;
  end

endmodule

// File: tb/tb_hilo_div_writer.sv
// Scoreboard bench for hilo_div_writer: driver queues expected writes, a monitor checks each hilo_we.
module tb_hilo_div_writer;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic           signed_div;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           cancel;
  logic           busy;
  logic           hilo_we;
  logic [2*W-1:0] hilo_o;

  typedef struct {
    logic [2*W-1:0] data;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   tests;
  int   fails;

  hilo_div_writer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .busy       (busy),
    .hilo_we    (hilo_we),
    .hilo_o     (hilo_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division, truncating toward zero; divide by zero is a fixed pattern
  function automatic logic [2*W-1:0] model(input bit sd, input logic [W-1:0] av, input logic [W-1:0] bv);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (bv == 0) return {av, {W{1'b1}}};
    if (sd) begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      q  = sa / sb;
      r  = sa % sb;
      return {r[W-1:0], q[W-1:0]};
    end
    uq = av / bv;
    ur = av % bv;
    return {ur, uq};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst && hilo_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got hilo_o=0x%0h at cycle %0d, expected no write", hilo_o, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hilo_o", hilo_o, e.data);
        check("write_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic do_div(input bit sd, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   bc;
    bit   fast;
    bit   done;
    fast = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    fast = (bv == 0);
`endif
    @(negedge clk);
    signed_div = sd;
    a          = av;
    b          = bv;
    start      = 1'b1;
    e.data     = model(sd, av, bv);
    e.cyc      = cyc + (fast ? 1 : W + 1);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    #1;
    bc   = 0;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) bc++;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no hilo_we within 100 cycles, expected a write");
      exp_q.delete();
    end
    check("busy_cycles", 64'(bc), fast ? 64'd0 : 64'(W));
  endtask

  logic [2*W-1:0] prev;

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    cancel     = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_we", 64'(hilo_we), 64'd0);
    check("reset_hilo", hilo_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2);
    do_div(1'b1, 32'd7, 32'hFFFFFFFE);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
    do_div(1'b0, 32'h80000000, 32'hFFFFFFFF);
    do_div(1'b0, 32'h12345678, 32'd0);
    do_div(1'b1, 32'h12345678, 32'd0);
    do_div(1'b1, 32'h87654321, 32'd0);

    // Cancel on the 10th DIV cycle
    prev = hilo_o;
    @(negedge clk);
    signed_div = 1'b0;
    a          = 32'd100;
    b          = 32'd7;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hilo", hilo_o, prev);
    repeat (40) @(negedge clk);
    check("cancel_hilo_held", hilo_o, prev);
    do_div(1'b0, 32'd9, 32'd3);

    // Asynchronous reset mid-division
    @(negedge clk);
    signed_div = 1'b0;
    a          = 32'd1000;
    b          = 32'd3;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_we", 64'(hilo_we), 64'd0);
    check("arst_hilo", hilo_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_no_write", hilo_o, 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      bit           rs;
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'h80000000;
        4: rb = {1'b1, 31'($urandom_range(0, 100))};
        default: ;
      endcase
      do_div(rs, ra, rb);
    end

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
